// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Opcodes, flag indices and EX/MEM stage state encoding.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_if
// Brief    : EX-side inputs and MEM-side registered outputs of the EX/MEM stage.
// Revision : 1.0
// ============================================================================
interface ex_mem_stage_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          stall;
    logic          flush;
    logic          in_valid;
    logic [3:0]    opcode;
    logic [DW-1:0] alu_result;
    logic          alu_ovfl;
    logic [DW-1:0] st_data;
    logic [RW-1:0] dst_reg;
    logic          reg_wr;
    logic          mem_wr;
    logic          mem_rd;

    logic          out_valid;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_st_data;
    logic [RW-1:0] out_dst_reg;
    logic          out_reg_wr;
    logic          out_mem_wr;
    logic          out_mem_rd;
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;
    logic          halted;

    modport slave (
        input  stall, flush, in_valid, opcode, alu_result, alu_ovfl,
               st_data, dst_reg, reg_wr, mem_wr, mem_rd,
        output out_valid, out_result, out_st_data, out_dst_reg,
               out_reg_wr, out_mem_wr, out_mem_rd,
               flag_z, flag_v, flag_n, halted
    );

    modport master (
        output stall, flush, in_valid, opcode, alu_result, alu_ovfl,
               st_data, dst_reg, reg_wr, mem_wr, mem_rd,
        input  out_valid, out_result, out_st_data, out_dst_reg,
               out_reg_wr, out_mem_wr, out_mem_rd,
               flag_z, flag_v, flag_n, halted
    );
endinterface
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_unit
// Brief    : Per-opcode Z/V/N update enables and next values.
// Revision : 1.0
// ============================================================================
module flag_unit
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  wire logic [3:0]    opcode,
    input  wire logic [DW-1:0] aluResult,
    input  wire logic          aluOvfl,
    output logic      [2:0]    flagEn,
    output logic      [2:0]    flagVal
);

    always_comb begin
        flagEn          = 3'b000;
        flagVal         = 3'b000;
        flagVal[FLAG_Z] = (aluResult == '0);
        flagVal[FLAG_V] = aluOvfl;
        flagVal[FLAG_N] = aluResult[DW-1];
        case (opcode)
            OP_ADD, OP_SUB:                 flagEn = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flagEn[FLAG_Z] = 1'b1;
            default:                        flagEn = 3'b000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline register with Z/V/N flag register and halt FSM.
// Revision : 1.0
// ============================================================================
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input wire logic      clk,
    input wire logic      rst,
    ex_mem_stage_if.slave bus
);

    state_t        r_state;
    state_t        w_nextState;
    logic          w_accept;
    logic          w_isHlt;
    logic [2:0]    w_flagEn;
    logic [2:0]    w_flagVal;

    logic          r_valid;
    logic [DW-1:0] r_result;
    logic [DW-1:0] r_stData;
    logic [RW-1:0] r_dstReg;
    logic          r_regWr;
    logic          r_memWr;
    logic          r_memRd;
    logic [2:0]    r_flags;

    assign w_isHlt  = (bus.opcode == OP_HLT);
    assign w_accept = bus.in_valid & ~bus.flush & ~bus.stall & (r_state == RUN);

    flag_unit #(.DW(DW)) u_flagUnit (
        .opcode    (bus.opcode),
        .aluResult (bus.alu_result),
        .aluOvfl   (bus.alu_ovfl),
        .flagEn    (w_flagEn),
        .flagVal   (w_flagVal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (w_accept && w_isHlt) w_nextState = HALTED;
    end

    // Flush beats stall; a non-accepted, non-stalled cycle becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_stData <= '0;
            r_dstReg <= '0;
            r_regWr  <= 1'b0;
            r_memWr  <= 1'b0;
            r_memRd  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= bus.alu_result;
            r_stData <= bus.st_data;
            r_dstReg <= bus.dst_reg;
            r_regWr  <= bus.reg_wr & ~w_isHlt;
            r_memWr  <= bus.mem_wr & ~w_isHlt;
            r_memRd  <= bus.mem_rd & ~w_isHlt;
        end else if (bus.flush || !bus.stall) begin
            r_valid  <= 1'b0;
            r_regWr  <= 1'b0;
            r_memWr  <= 1'b0;
            r_memRd  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_flags <= 3'b000;
        else if (w_accept) r_flags <= (r_flags & ~w_flagEn) | (w_flagVal & w_flagEn);
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_result  = r_result;
    assign bus.out_st_data = r_stData;
    assign bus.out_dst_reg = r_dstReg;
    assign bus.out_reg_wr  = r_regWr;
    assign bus.out_mem_wr  = r_memWr;
    assign bus.out_mem_rd  = r_memRd;
    assign bus.flag_z      = r_flags[FLAG_Z];
    assign bus.flag_v      = r_flags[FLAG_V];
    assign bus.flag_n      = r_flags[FLAG_N];
    assign bus.halted      = (r_state == HALTED);

endmodule
`default_nettype wire
